// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: command field layout,
// transfer length codes and the stage state encoding.
package mem_pkg;

    localparam int E_EN     = 4;
    localparam int E_LEN_HI = 3;
    localparam int E_LEN_LO = 2;
    localparam int E_WR     = 1;
    localparam int E_UNS    = 0;

    // Length codes hold (byte count - 1)
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_ext.sv
// Load-result extension: widens the assembled byte buffer to 32 bits
// according to the transfer length and the unsigned flag.
module mem_ext
    import mem_pkg::*;
(
    input  logic [31:0] buf_i,
    input  logic [1:0]  len_i,
    input  logic        uns_i,
    output logic [31:0] val_o
);

    always_comb begin
        val_o = buf_i;
        case (len_i)
            LEN_B:   val_o = {{24{~uns_i & buf_i[7]}}, buf_i[7:0]};
            LEN_H:   val_o = {{16{~uns_i & buf_i[15]}}, buf_i[15:0]};
            LEN_W:   val_o = buf_i;
            // Three-byte loads always zero-extend; the top buffer byte may be stale
            default: val_o = {8'h00, buf_i[23:0]};
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over a shared 8-bit RAM port
// behind a req/grant arbiter, with registered writeback outputs.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wa_i,
    input  logic              we_i,
    input  logic [31:0]       res_i,
    input  logic [4:0]        mem_e_i,
    input  logic [31:0]       mem_n_i,
    output logic              stall_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i,
    output logic [4:0]        wa_o,
    output logic              we_o,
    output logic [31:0]       wdata_o
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic        uns_q, uns_d;
    logic        pend_q, pend_d;
    logic        we_lat_q, we_lat_d;
    logic        we_q, we_d;
    logic [4:0]  wa_lat_q, wa_lat_d;
    logic [4:0]  wa_q, wa_d;

    logic        issue;
    logic [1:0]  cap_idx;
    logic [31:0] cap_buf;
    logic [31:0] ext_val;
    logic [7:0]  st_byte [4];

    // Read data returns one cycle after issue, by which time idx has already advanced
    assign cap_idx = idx_q - 2'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_byte[gi]         = sdata_q[8*gi +: 8];
            assign cap_buf[8*gi +: 8]  = (pend_q && (cap_idx == 2'(gi))) ? ram_din_i
                                                                         : buf_q[8*gi +: 8];
        end
    endgenerate

    mem_ext u_ext (
        .buf_i (buf_q),
        .len_i (len_q),
        .uns_i (uns_q),
        .val_o (ext_val)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        len_d     = len_q;
        wr_d      = wr_q;
        uns_d     = uns_q;
        wa_lat_d  = wa_lat_q;
        we_lat_d  = we_lat_q;
        idx_d     = idx_q;
        pend_d    = 1'b0;
        buf_d     = cap_buf;
        wa_d      = wa_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        issue     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_e_i[E_EN]) begin
                    stall_o  = 1'b1;
                    addr_d   = res_i;
                    sdata_d  = mem_n_i;
                    len_d    = mem_e_i[E_LEN_HI:E_LEN_LO];
                    wr_d     = mem_e_i[E_WR];
                    uns_d    = mem_e_i[E_UNS];
                    wa_lat_d = wa_i;
                    we_lat_d = we_i;
                    idx_d    = 2'd0;
                    state_d  = ST_XFER;
                end else begin
                    wa_d    = wa_i;
                    we_d    = we_i;
                    wdata_d = res_i;
                end
            end
            ST_XFER: begin
                stall_o   = 1'b1;
                mem_req_o = ~rst;
                if (mem_gnt_i && !rst) begin
                    issue  = 1'b1;
                    idx_d  = idx_q + 2'd1;
                    pend_d = ~wr_q;
                    if (idx_q == len_q) begin
                        state_d = wr_q ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                stall_o = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                wa_d    = wa_lat_q;
                we_d    = we_lat_q;
                wdata_d = wr_q ? addr_q : ext_val;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            sdata_q  <= '0;
            len_q    <= '0;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            wa_lat_q <= '0;
            we_lat_q <= 1'b0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            buf_q    <= '0;
            wa_q     <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            len_q    <= len_d;
            wr_q     <= wr_d;
            uns_q    <= uns_d;
            wa_lat_q <= wa_lat_d;
            we_lat_q <= we_lat_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            buf_q    <= buf_d;
            wa_q     <= wa_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ram_addr_o = addr_q[ADDR_W-1:0] + ADDR_W'(idx_q);
    assign ram_dout_o = st_byte[idx_q];
    assign ram_wr_o   = issue & wr_q;
    assign wa_o       = wa_q;
    assign we_o       = we_q;
    assign wdata_o    = wdata_q;

endmodule
